// File: rtl/univ_gate_pkg.sv
// Shared types, step ROM and step-count table for univ_gate_seq.
// Step ROM entries give (x operand, y operand, destination) per primitive step.
package univ_gate_pkg;

  typedef enum logic [2:0] {
    OP_PRIM, OP_AND, OP_OR, OP_NOT,
    OP_DUAL, OP_XOR, OP_XNOR, OP_BUF
  } op_e;

  typedef enum logic [1:0] {
    IDLE, EXEC, DONE
  } state_e;

  typedef enum logic [2:0] {
    SEL_A, SEL_B, SEL_T, SEL_U, SEL_V, SEL_R
  } sel_e;

  typedef struct packed {
    sel_e x;
    sel_e y;
    sel_e dst;
  } step_t;

  localparam int unsigned MAX_S = 5;

  function automatic step_t mk(
    input sel_e x,
    input sel_e y,
    input sel_e d
  );
    step_t s;
    s.x   = x;
    s.y   = y;
    s.dst = d;
    return s;
  endfunction

  // Step ROM [base][op][step]. A NOR base reuses the NAND
  // sequences with AND/OR and XOR/XNOR exchanged (duality).
  function automatic step_t step_rom(
    input logic       base,
    input op_e        op,
    input logic [2:0] idx
  );
    op_e   seq;
    step_t r;
    seq = op;
    if (base) begin
      case (op)
        OP_AND:  seq = OP_OR;
        OP_OR:   seq = OP_AND;
        OP_XOR:  seq = OP_XNOR;
        OP_XNOR: seq = OP_XOR;
        default: seq = op;
      endcase
    end
    r = mk(SEL_A, SEL_B, SEL_R);
    case (seq)
      OP_PRIM: r = mk(SEL_A, SEL_B, SEL_R);
      OP_AND:
        case (idx)
          3'd0:    r = mk(SEL_A, SEL_B, SEL_T);
          default: r = mk(SEL_T, SEL_T, SEL_R);
        endcase
      OP_OR:
        case (idx)
          3'd0:    r = mk(SEL_A, SEL_A, SEL_T);
          3'd1:    r = mk(SEL_B, SEL_B, SEL_U);
          default: r = mk(SEL_T, SEL_U, SEL_R);
        endcase
      OP_NOT: r = mk(SEL_A, SEL_A, SEL_R);
      OP_DUAL:
        case (idx)
          3'd0:    r = mk(SEL_A, SEL_A, SEL_T);
          3'd1:    r = mk(SEL_B, SEL_B, SEL_U);
          3'd2:    r = mk(SEL_T, SEL_U, SEL_V);
          default: r = mk(SEL_V, SEL_V, SEL_R);
        endcase
      OP_XOR:
        case (idx)
          3'd0:    r = mk(SEL_A, SEL_B, SEL_T);
          3'd1:    r = mk(SEL_A, SEL_T, SEL_U);
          3'd2:    r = mk(SEL_B, SEL_T, SEL_V);
          default: r = mk(SEL_U, SEL_V, SEL_R);
        endcase
      OP_XNOR:
        case (idx)
          3'd0:    r = mk(SEL_A, SEL_B, SEL_T);
          3'd1:    r = mk(SEL_A, SEL_T, SEL_U);
          3'd2:    r = mk(SEL_B, SEL_T, SEL_V);
          3'd3:    r = mk(SEL_U, SEL_V, SEL_T);
          default: r = mk(SEL_T, SEL_T, SEL_R);
        endcase
      OP_BUF:
        case (idx)
          3'd0:    r = mk(SEL_A, SEL_A, SEL_T);
          default: r = mk(SEL_T, SEL_T, SEL_R);
        endcase
      default: r = mk(SEL_A, SEL_B, SEL_R);
    endcase
    return r;
  endfunction

  // Step count S[base][op].
  function automatic logic [2:0] step_cnt(
    input logic base,
    input op_e  op
  );
    case (op)
      OP_PRIM: return 3'd1;
      OP_AND:  return base ? 3'd3 : 3'd2;
      OP_OR:   return base ? 3'd2 : 3'd3;
      OP_NOT:  return 3'd1;
      OP_DUAL: return 3'd4;
      OP_XOR:  return base ? 3'd5 : 3'd4;
      OP_XNOR: return base ? 3'd4 : 3'd5;
      OP_BUF:  return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/univ_prim.sv
// Universal primitive: z = NAND(x,y) when BASE=0, NOR(x,y) when BASE=1.
// Ports: x, y operands (WIDTH); z result (WIDTH). Pure combinational.
module univ_prim #(
  parameter int WIDTH = 8,
  parameter int BASE  = 0
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z
);

  if (BASE != 0) begin : g_nor
    assign z = ~(x | y);
  end else begin : g_nand
    assign z = ~(x & y);
  end

endmodule

// File: rtl/univ_gate_seq.sv
// Micro-sequenced 2-input logic unit built from one NAND/NOR primitive.
// Ports: clk, rst_n; in_valid/in_ready, op, in1, in2; out_valid/out_ready, out, out_steps.
module univ_gate_seq
  import univ_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BASE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       out_steps
);

  localparam logic BSEL = (BASE != 0);

  state_e           state, state_nx;
  op_e              op_q;
  logic [2:0]       cnt;
  logic [2:0]       s_len;
  logic             last;
  step_t            st;
  logic [WIDTH-1:0] a, b, t, u, v;
  logic [WIDTH-1:0] x, y, z;

  assign st    = step_rom(BSEL, op_q, cnt);
  assign s_len = step_cnt(BSEL, op_q);
  assign last  = (cnt == s_len - 3'd1);

  always_comb begin
    x = '0;
    case (st.x)
      SEL_A:   x = a;
      SEL_B:   x = b;
      SEL_T:   x = t;
      SEL_U:   x = u;
      SEL_V:   x = v;
      default: x = '0;
    endcase
  end

  always_comb begin
    y = '0;
    case (st.y)
      SEL_A:   y = a;
      SEL_B:   y = b;
      SEL_T:   y = t;
      SEL_U:   y = u;
      SEL_V:   y = v;
      default: y = '0;
    endcase
  end

  univ_prim #(
    .WIDTH(WIDTH),
    .BASE (BASE)
  ) u_prim (
    .x(x),
    .y(y),
    .z(z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = EXEC;
      EXEC:    if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a         <= '0;
      b         <= '0;
      t         <= '0;
      u         <= '0;
      v         <= '0;
      op_q      <= OP_PRIM;
      cnt       <= '0;
      out       <= '0;
      out_steps <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (in_valid) begin
            a    <= in1;
            b    <= in2;
            op_q <= op_e'(op);
            t    <= '0;
            u    <= '0;
            v    <= '0;
            cnt  <= '0;
          end
        end
        (state == EXEC): begin
          cnt <= cnt + 3'd1;
          case (st.dst)
            SEL_T: t <= z;
            SEL_U: u <= z;
            SEL_V: v <= z;
            SEL_R: begin
              out       <= z;
              out_steps <= s_len;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_univ_gate_seq.sv
// Directed/table-driven bench for univ_gate_seq (NAND and NOR bases,
// 8-bit, plus 64-bit and 1-bit NOR builds under random stimulus).
module tb_univ_gate_seq;

  logic clk = 1'b0;
  logic rst_n;

  logic [1:0]      in_valid, in_ready, out_valid, out_ready;
  logic [1:0][2:0] op;
  logic [1:0][7:0] in1, in2, out;
  logic [1:0][2:0] steps;

  logic        wv, wr;
  logic [2:0]  w_op;
  logic [63:0] w_a, w_b, w64_out;
  logic        w64_rdy, w64_vld, w1_rdy, w1_vld;
  logic [0:0]  w1_out;
  logic [2:0]  w64_steps, w1_steps;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    univ_gate_seq #(.WIDTH(8), .BASE(g)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .op       (op[g]),
      .in1      (in1[g]),
      .in2      (in2[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out      (out[g]),
      .out_steps(steps[g])
    );
  end

  univ_gate_seq #(.WIDTH(64), .BASE(1)) dut_w64 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (wv),
    .in_ready (w64_rdy),
    .op       (w_op),
    .in1      (w_a),
    .in2      (w_b),
    .out_valid(w64_vld),
    .out_ready(wr),
    .out      (w64_out),
    .out_steps(w64_steps)
  );

  univ_gate_seq #(.WIDTH(1), .BASE(1)) dut_w1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (wv),
    .in_ready (w1_rdy),
    .op       (w_op),
    .in1      (w_a[0:0]),
    .in2      (w_b[0:0]),
    .out_valid(w1_vld),
    .out_ready(wr),
    .out      (w1_out),
    .out_steps(w1_steps)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_fn(input int base, input logic [2:0] o,
                                         input logic [63:0] x, input logic [63:0] y);
    case (o)
      3'd0:    return (base != 0) ? ~(x | y) : ~(x & y);
      3'd1:    return x & y;
      3'd2:    return x | y;
      3'd3:    return ~x;
      3'd4:    return (base != 0) ? ~(x & y) : ~(x | y);
      3'd5:    return x ^ y;
      3'd6:    return ~(x ^ y);
      default: return x;
    endcase
  endfunction

  function automatic int s_of(input int base, input logic [2:0] o);
    case (o)
      3'd0:    return 1;
      3'd1:    return (base != 0) ? 3 : 2;
      3'd2:    return (base != 0) ? 2 : 3;
      3'd3:    return 1;
      3'd4:    return 4;
      3'd5:    return (base != 0) ? 5 : 4;
      3'd6:    return (base != 0) ? 4 : 5;
      default: return 2;
    endcase
  endfunction

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic accept(input int g, input logic [2:0] o,
                        input logic [7:0] x, input logic [7:0] y);
    chk("in_ready_before_accept", in_ready[g], 1);
    op[g]       = o;
    in1[g]      = x;
    in2[g]      = y;
    in_valid[g] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
    in1[g]      = 8'($urandom);
    in2[g]      = 8'($urandom);
    op[g]       = 3'($urandom);
  endtask

  task automatic wait_valid(input int g, output int lat);
    lat = 0;
    while (!out_valid[g] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  typedef struct {
    int         base;
    logic [2:0] op;
    logic [7:0] exp;
    logic [2:0] st;
  } vec_t;

  vec_t tv[16];

  initial begin
    logic [7:0] e0[8];
    logic [7:0] e1[8];
    logic [2:0] s0[8];
    logic [2:0] s1[8];
    logic [63:0] e;
    logic [2:0]  p_op, a_op;
    logic [7:0]  p_a, p_b, a_a, a_b;
    logic        rdy;
    int lat, last_acc, last_s, g;

    e0 = '{8'h7E, 8'h81, 8'hE7, 8'h3C, 8'h18, 8'h66, 8'h99, 8'hC3};
    e1 = '{8'h18, 8'h81, 8'hE7, 8'h3C, 8'h7E, 8'h66, 8'h99, 8'hC3};
    s0 = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd4, 3'd4, 3'd5, 3'd2};
    s1 = '{3'd1, 3'd3, 3'd2, 3'd1, 3'd4, 3'd5, 3'd4, 3'd2};
    for (int i = 0; i < 8; i++) begin
      tv[i]     = '{0, 3'(i), e0[i], s0[i]};
      tv[i + 8] = '{1, 3'(i), e1[i], s1[i]};
    end

    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '1;
    op        = '0;
    in1       = '0;
    in2       = '0;
    wv        = 1'b0;
    wr        = 1'b1;
    w_op      = '0;
    w_a       = '0;
    w_b       = '0;

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", in_ready[i], 1);
      chk("rst_out_valid", out_valid[i], 0);
      chk("rst_out", out[i], 0);
      chk("rst_steps", steps[i], 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: every op on both bases, back to back
    for (int i = 0; i < 16; i++) begin
      g = tv[i].base;
      accept(g, tv[i].op, 8'hC3, 8'hA5);
      wait_valid(g, lat);
      chk($sformatf("latency b%0d op%0d", g, tv[i].op), lat, tv[i].st);
      chk($sformatf("out b%0d op%0d", g, tv[i].op), out[g], tv[i].exp);
      chk($sformatf("steps b%0d op%0d", g, tv[i].op), steps[g], tv[i].st);
      @(posedge clk);
      #1;
      chk("drained_valid", out_valid[g], 0);
      chk("drained_in_ready", in_ready[g], 1);
      chk("out_held_after_drain", out[g], tv[i].exp);
    end

    // Backpressure: XOR held 10 cycles
    out_ready[0] = 1'b0;
    accept(0, 3'd5, 8'hC3, 8'hA5);
    wait_valid(0, lat);
    chk("bp_latency", lat, 4);
    for (int k = 0; k < 10; k++) begin
      chk("bp_out", out[0], 8'h66);
      chk("bp_valid", out_valid[0], 1);
      chk("bp_in_ready", in_ready[0], 0);
      chk("bp_steps", steps[0], 4);
      @(posedge clk);
      #1;
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_drain_valid", out_valid[0], 0);
    chk("bp_drain_in_ready", in_ready[0], 1);

    // Continuous in_valid with fresh operands every cycle
    last_acc    = -1;
    last_s      = 0;
    a_op        = '0;
    a_a         = '0;
    a_b         = '0;
    in_valid[0] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      p_op   = 3'($urandom);
      p_a    = 8'($urandom);
      p_b    = 8'($urandom);
      op[0]  = p_op;
      in1[0] = p_a;
      in2[0] = p_b;
      rdy    = in_ready[0];
      @(posedge clk);
      #1;
      if (rdy) begin
        if (last_acc >= 0) chk("stream_accept_gap", c - last_acc, last_s + 2);
        last_acc = c;
        last_s   = s_of(0, p_op);
        a_op     = p_op;
        a_a      = p_a;
        a_b      = p_b;
      end
      if (out_valid[0]) begin
        e = ref_fn(0, a_op, {56'd0, a_a}, {56'd0, a_b});
        chk("stream_out", out[0], {56'd0, e[7:0]});
        chk("stream_steps", steps[0], s_of(0, a_op));
      end
    end
    in_valid[0] = 1'b0;
    for (int k = 0; k < 10 && !in_ready[0]; k++) begin
      @(posedge clk);
      #1;
    end
    chk("stream_idle", in_ready[0], 1);
    @(posedge clk);
    #1;

    // Reset mid-EXEC (XNOR after step 2)
    accept(0, 3'd6, 8'hC3, 8'hA5);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_valid", out_valid[0], 0);
    chk("abort_out", out[0], 0);
    chk("abort_in_ready", in_ready[0], 1);
    chk("abort_steps", steps[0], 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("abort_hold_valid", out_valid[0], 0);
      chk("abort_hold_out", out[0], 0);
    end
    rst_n = 1'b1;
    accept(0, 3'd0, 8'hC3, 8'hA5);
    wait_valid(0, lat);
    chk("post_rst_latency", lat, 1);
    chk("post_rst_out", out[0], 8'h7E);
    chk("post_rst_steps", steps[0], 1);
    @(posedge clk);
    #1;

    // 64-bit and 1-bit NOR builds, lockstep
    for (int k = 0; k < 16; k++) begin
      w_op = (k < 8) ? 3'(k) : 3'($urandom);
      w_a  = {$urandom, $urandom};
      w_b  = {$urandom, $urandom};
      chk("w_in_ready", {w64_rdy, w1_rdy}, 2'b11);
      wv = 1'b1;
      @(posedge clk);
      #1;
      wv  = 1'b0;
      w_a = {$urandom, $urandom};
      w_b = {$urandom, $urandom};
      lat = 0;
      while (!w64_vld && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk($sformatf("w_latency op%0d", w_op), lat, s_of(1, w_op));
      chk("w1_valid", w1_vld, 1);
      chk("w64_steps", w64_steps, s_of(1, w_op));
      chk("w1_steps", w1_steps, s_of(1, w_op));
      w_op = w_op;
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Result check for the wide builds, sampled when out_valid is seen
  logic [63:0] w_ea, w_eb;
  logic [2:0]  w_eo;
  logic [63:0] w_exp;
  always @(posedge clk) begin
    if (wv && w64_rdy) begin
      w_ea <= w_a;
      w_eb <= w_b;
      w_eo <= w_op;
    end
  end
  always @(negedge clk) begin
    if (rst_n && w64_vld) begin
      w_exp = ref_fn(1, w_eo, w_ea, w_eb);
      chk("w64_out", w64_out, w_exp);
      chk("w1_out", {63'd0, w1_out}, {63'd0, w_exp[0]});
    end
  end

endmodule
